// File: rtl/rx_iq_fifo.sv
// Show-ahead I/Q sample-set FIFO between the RX DDC and the MCU bus. A write is visible after one edge; a pop takes effect at the edge after read_clk rises.
// There is no backpressure: a write into a full FIFO is dropped and flagged (overrun), and a pop while empty is ignored and flagged (underrun).
module rx_iq_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 24
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      rx1_i_in,
  input  logic [WIDTH-1:0]      rx1_q_in,
  input  logic [WIDTH-1:0]      rx2_i_in,
  input  logic [WIDTH-1:0]      rx2_q_in,
  input  logic                  rx_valid,
  input  logic                  read_req,
  input  logic                  read_clk,
  input  logic                  flush,
  input  logic                  flag_clr,
  output logic [WIDTH-1:0]      RX1_I,
  output logic [WIDTH-1:0]      RX1_Q,
  output logic [WIDTH-1:0]      RX2_I,
  output logic [WIDTH-1:0]      RX2_Q,
  output logic                  in_empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  typedef struct packed {
    logic [WIDTH-1:0] rx1_i;
    logic [WIDTH-1:0] rx1_q;
    logic [WIDTH-1:0] rx2_i;
    logic [WIDTH-1:0] rx2_q;
  } iq_t;

  iq_t                 mem [DEPTH];
  iq_t                 wr_dat;
  iq_t                 head;
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                read_clk_d;
  logic                empty;
  logic                pop_req;
  logic                do_pop;
  logic                do_wr;
  logic                ovr_evt;
  logic                unr_evt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level = wr_ptr - rd_ptr;

  // Only the rising edge of the bus read clock pops; holding it high pops once.
  assign pop_req = read_clk & ~read_clk_d & read_req;
  assign do_pop  = pop_req & ~empty;
  assign unr_evt = pop_req & empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign do_wr   = rx_valid & (~full | do_pop);
  assign ovr_evt = rx_valid & full & ~do_pop;

  assign wr_dat = '{rx1_i: rx1_i_in, rx1_q: rx1_q_in, rx2_i: rx2_i_in, rx2_q: rx2_q_in};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      read_clk_d <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      read_clk_d <= read_clk;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overrun  <= 1'b0;
        underrun <= 1'b0;
      end else begin
        if (do_wr)  wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
        overrun  <= (overrun  & ~flag_clr) | ovr_evt;
        underrun <= (underrun & ~flag_clr) | unr_evt;
      end
    end
  end

  // Storage is deliberately not reset; the empty gate below hides stale contents.
  always_ff @(posedge clk_in) begin
    if (do_wr && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_dat;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  assign RX1_I    = head.rx1_i;
  assign RX1_Q    = head.rx1_q;
  assign RX2_I    = head.rx2_i;
  assign RX2_Q    = head.rx2_q;
  assign in_empty = empty;

endmodule

// File: tb/tb_rx_iq_fifo.sv
// Bench for rx_iq_fifo: directed vector table, hand sequences and random traffic against a queue model.
module tb_rx_iq_fifo;

  localparam int DL = 4;
  localparam int W  = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  rx1_i_in = '0, rx1_q_in = '0, rx2_i_in = '0, rx2_q_in = '0;
  logic          rx_valid = 1'b0, read_req = 1'b0, read_clk = 1'b0, flush = 1'b0, flag_clr = 1'b0;
  logic [W-1:0]  RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic          in_empty, full, overrun, underrun;
  logic [DL:0]   level;

  rx_iq_fifo #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk_in(clk), .reset_n(reset_n),
    .rx1_i_in(rx1_i_in), .rx1_q_in(rx1_q_in), .rx2_i_in(rx2_i_in), .rx2_q_in(rx2_q_in),
    .rx_valid(rx_valid), .read_req(read_req), .read_clk(read_clk),
    .flush(flush), .flag_clr(flag_clr),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
    .in_empty(in_empty), .full(full), .level(level),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain queue of sample sets plus sticky flags.
  logic [4*W-1:0] mq[$];
  logic           m_ovr = 1'b0, m_unr = 1'b0, m_prev_rc = 1'b0;

  typedef struct {
    logic v, rq, rc, fl, fc;
    logic [W-1:0] d;
    int   e_level;
    logic e_empty, e_full, e_ovr, e_unr;
    logic [W-1:0] e_head;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic rq, logic rc, logic fl, logic fc, int d,
                              int lv, logic em, logic fu, logic ov, logic un, int hd);
    vec_t t;
    t.v = v; t.rq = rq; t.rc = rc; t.fl = fl; t.fc = fc; t.d = d[W-1:0];
    t.e_level = lv; t.e_empty = em; t.e_full = fu; t.e_ovr = ov; t.e_unr = un;
    t.e_head = hd[W-1:0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovr = 1'b0; m_unr = 1'b0; m_prev_rc = 1'b0;
  endfunction

  function automatic void model_step(logic v, logic rq, logic rc, logic fl, logic fc, logic [4*W-1:0] e);
    logic pop, was_empty, was_full, ov_e, un_e;
    pop       = rc && !m_prev_rc && rq;
    m_prev_rc = rc;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    ov_e = 1'b0; un_e = 1'b0;
    if (fl) begin
      mq.delete();
      m_ovr = 1'b0; m_unr = 1'b0;
    end else begin
      if (pop) begin
        if (was_empty) un_e = 1'b1;
        else void'(mq.pop_front());
      end
      if (v) begin
        if (was_full && !pop) ov_e = 1'b1;
        else mq.push_back(e);
      end
      m_ovr = (m_ovr && !fc) || ov_e;
      m_unr = (m_unr && !fc) || un_e;
    end
  endfunction

  task automatic apply(input logic v, input logic rq, input logic rc, input logic fl,
                       input logic fc, input logic [W-1:0] d);
    logic [4*W-1:0] e;
    e = {d, d + 24'h100, d + 24'h200, d + 24'h300};
    rx_valid = v; read_req = rq; read_clk = rc; flush = fl; flag_clr = fc;
    {rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in} = e;
    model_step(v, rq, rc, fl, fc, e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [4*W-1:0] h;
    h = (mq.size() == 0) ? '0 : mq[0];
    chk({tag, ".level"},    32'(level),    32'(mq.size()));
    chk({tag, ".in_empty"}, 32'(in_empty), 32'(mq.size() == 0));
    chk({tag, ".full"},     32'(full),     32'(mq.size() == DEPTH));
    chk({tag, ".overrun"},  32'(overrun),  32'(m_ovr));
    chk({tag, ".underrun"}, 32'(underrun), 32'(m_unr));
    chk({tag, ".data"},     32'({RX1_I, RX1_Q, RX2_I, RX2_Q} == h), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".level"},    32'(level),    32'd0);
    chk({tag, ".in_empty"}, 32'(in_empty), 32'd1);
    chk({tag, ".full"},     32'(full),     32'd0);
    chk({tag, ".overrun"},  32'(overrun),  32'd0);
    chk({tag, ".underrun"}, 32'(underrun), 32'd0);
    chk({tag, ".data"},     32'(RX1_I | RX1_Q | RX2_I | RX2_Q), 32'd0);
  endtask

  initial begin
    //              v  rq rc fl fc  d   | lvl emp ful ovr unr head
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,    1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2,    2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3,    3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    2, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    2, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    0, 1, 0, 0, 1, 0));   // pop while empty
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,    0, 1, 0, 0, 0, 0));   // flag_clr
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0,    0, 1, 0, 0, 1, 0));   // set beats clear
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,    0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 10,   1, 0, 0, 0, 0, 10));
    tbl.push_back(mk(1, 0, 0, 0, 0, 11,   2, 0, 0, 0, 0, 10));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,    2, 0, 0, 0, 0, 10));  // read_req low: no pop
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    2, 0, 0, 0, 0, 10));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    1, 0, 0, 0, 0, 11));  // held high 5 cycles
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    1, 0, 0, 0, 0, 11));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    1, 0, 0, 0, 0, 11));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    1, 0, 0, 0, 0, 11));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    1, 0, 0, 0, 0, 11));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 11));
    tbl.push_back(mk(1, 1, 1, 0, 0, 12,   1, 0, 0, 0, 0, 12));  // write+pop, non-empty
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 12));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,    0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 13,   1, 0, 0, 0, 1, 13));  // write+pop while empty
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,    1, 0, 0, 0, 0, 13));
    tbl.push_back(mk(1, 1, 1, 1, 0, 14,   0, 1, 0, 0, 0, 0));   // flush ignores write/pop
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].rq, tbl[i].rc, tbl[i].fl, tbl[i].fc, tbl[i].d);
      chk($sformatf("vec%0d.level", i),    32'(level),    32'(tbl[i].e_level));
      chk($sformatf("vec%0d.in_empty", i), 32'(in_empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d.full", i),     32'(full),     32'(tbl[i].e_full));
      chk($sformatf("vec%0d.overrun", i),  32'(overrun),  32'(tbl[i].e_ovr));
      chk($sformatf("vec%0d.underrun", i), 32'(underrun), 32'(tbl[i].e_unr));
      chk($sformatf("vec%0d.rx1_i", i),    32'(RX1_I),    32'(tbl[i].e_head));
      if (tbl[i].e_level != 0)
        chk($sformatf("vec%0d.rx2_q", i), 32'(RX2_Q), 32'(tbl[i].e_head + 24'h300));
    end

    // Overflow: 17 writes into 16 entries.
    for (int k = 1; k <= 17; k++) apply(1, 0, 0, 0, 0, W'(k));
    check_model("ovf");
    chk("ovf.level16", 32'(level), 32'd16);
    chk("ovf.full",    32'(full),  32'd1);
    chk("ovf.overrun", 32'(overrun), 32'd1);
    apply(0, 0, 0, 0, 1, 0);
    chk("ovf.cleared", 32'(overrun), 32'd0);
    // Write and pop together while full: accepted, no overrun.
    apply(1, 1, 1, 0, 0, 24'h77);
    check_model("fullwp");
    chk("fullwp.level", 32'(level), 32'd16);
    chk("fullwp.overrun", 32'(overrun), 32'd0);
    apply(0, 1, 0, 0, 0, 0);
    // Drain: heads must be 2..16 then 0x77; entry 17 never appears.
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d.head", k), 32'(RX1_I), (k < 15) ? 32'(k + 2) : 32'h77);
      apply(0, 1, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0);
      check_model($sformatf("drain%0d", k));
    end

    // Flush with 5 entries, overrun set and a same-cycle write.
    for (int k = 1; k <= 17; k++) apply(1, 0, 0, 0, 0, W'(k + 32));
    for (int k = 0; k < 11; k++) begin
      apply(0, 1, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0);
    end
    check_model("preflush");
    chk("preflush.level", 32'(level), 32'd5);
    apply(1, 0, 0, 1, 0, 24'h55);
    check_model("flush");
    chk("flush.level", 32'(level), 32'd0);
    chk("flush.overrun", 32'(overrun), 32'd0);

    // Asynchronous reset mid-burst, with read_clk high.
    for (int k = 1; k <= 3; k++) apply(1, 0, 0, 0, 0, W'(k + 64));
    read_clk = 1'b1; read_req = 1'b1; rx_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    read_clk = 1'b0; read_req = 1'b0; rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("arst_hold");
    reset_n = 1'b1;
    apply(1, 0, 0, 0, 0, 24'h99);
    check_model("post_rst_wr");
    apply(0, 1, 1, 0, 0, 0);
    check_model("post_rst_pop");

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int seg = 0; seg < 8; seg++) begin
      int wb;
      wb = (seg % 2 == 0) ? 80 : 25;
      for (int c = 0; c < 250; c++) begin
        apply($urandom_range(0, 99) < wb, $urandom_range(0, 9) != 0, 1'($urandom),
              $urandom_range(0, 127) == 0, $urandom_range(0, 15) == 0, W'($urandom));
        check_model($sformatf("rnd%0d_%0d", seg, c));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
